// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment scanner for the board debug display.
// Picks one source word, shows a page of its nibbles MSD first.
//
// Ports:
//   clock    system clock, rising edge
//   reset    asynchronous active-low reset
//   src_bus  NUM_SRC words of DATA_W bits, word k at [k*DATA_W +: DATA_W]
//   sel      source index (switch, asynchronous)
//   page     nibble-window index (switch, asynchronous)
//   blank_lz leading-zero blanking enable (switch, asynchronous)
//   freeze   hold the displayed value (switch, asynchronous)
//   annode   one-hot digit enables, active-high, bit 0 = least significant
//   cathod   segments {a,b,c,d,e,f,g}, active-low
module ssd_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 32,
    parameter int NUM_SRC    = 32,
    parameter int SEL_W      = 6,
    parameter int PAGE_W     = 1,
    parameter int DIV        = 200000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_SRC*DATA_W-1:0] src_bus,
    input  logic [SEL_W-1:0]          sel,
    input  logic [PAGE_W-1:0]         page,
    input  logic                      blank_lz,
    input  logic                      freeze,
    output logic [NUM_DIGITS-1:0]     annode,
    output logic [6:0]                cathod
);

    localparam int WIN_W = 4 * NUM_DIGITS;
    localparam int PW    = $clog2(NUM_DIGITS);
    localparam int CW    = $clog2(DIV);
    localparam int SW    = SEL_W + PAGE_W + 2;

    localparam logic [PW-1:0] P_TOP = PW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] C_TOP = CW'(DIV - 1);

    logic [SW-1:0]     sw_m;
    logic [SW-1:0]     sw_s;
    logic [SEL_W-1:0]  sel_s;
    logic [PAGE_W-1:0] page_s;
    logic              blz_s;
    logic              frz_s;

    logic [CW-1:0]     cnt;
    logic              tick;
    logic [PW-1:0]     p;
    logic [WIN_W-1:0]  frame_val;
    logic [DATA_W-1:0] word;
    logic [WIN_W-1:0]  window;
    logic [3:0]        nib;
    logic              blank;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h01;
            4'h1: hex7 = 7'h4F;
            4'h2: hex7 = 7'h12;
            4'h3: hex7 = 7'h06;
            4'h4: hex7 = 7'h4C;
            4'h5: hex7 = 7'h24;
            4'h6: hex7 = 7'h20;
            4'h7: hex7 = 7'h0F;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h04;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h60;
            4'hC: hex7 = 7'h31;
            4'hD: hex7 = 7'h42;
            4'hE: hex7 = 7'h30;
            4'hF: hex7 = 7'h38;
        endcase
    endfunction

    // All switch inputs share one two-flop synchroniser.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_m <= '0;
            sw_s <= '0;
        end else begin
            sw_m <= {sel, page, blank_lz, freeze};
            sw_s <= sw_m;
        end
    end

    assign {sel_s, page_s, blz_s, frz_s} = sw_s;

    // Out-of-range selects leave the word at zero.
    always_comb begin
        word = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (int'(sel_s) == k) begin
                word = src_bus[k*DATA_W +: DATA_W];
            end
        end
    end

    // Zero-extend so pages past the top of the word read as zero.
    assign window = WIN_W'({{WIN_W{1'b0}}, word} >> (int'(page_s) * WIN_W));

    assign tick  = (cnt == C_TOP);
    assign nib   = frame_val[{p, 2'b00} +: 4];
    assign blank = blz_s && (p != '0) && ((frame_val >> {p, 2'b00}) == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

    // The digit-0 nibble is taken from the old frame_val on the
    // capture tick, so every frame is shown from a single snapshot.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            p         <= P_TOP;
            frame_val <= '0;
            annode    <= '0;
            cathod    <= 7'h7F;
        end else if (tick) begin
            annode <= NUM_DIGITS'(1) << p;
            cathod <= blank ? 7'h7F : hex7(nib);
            if (p == '0) begin
                p <= P_TOP;
                if (!frz_s) begin
                    frame_val <= window;
                end
            end else begin
                p <= p - PW'(1);
            end
        end
    end

endmodule

// File: doc/ssd_scan_ctrl.md
# ssd_scan_ctrl

Parametrised multiplexed seven-segment scanner for the board debug display. It selects one word from a flat bus of processor-state sources (PC, register file), extracts a page of nibbles, and time-multiplexes them onto a common-cathode-bus digit array. Compared with the fixed 4-digit display path, it adds:
- configurable digit count, source count and refresh rate;
- page selection for words wider than the display;
- leading-zero blanking;
- a freeze mode;
- synchronised switch inputs;
- tear-free per-frame value capture.

## Interface
- NUM_DIGITS, 4, digits driven (≥2)
- DATA_W, 32, width of each source word
- NUM_SRC, 32, number of source words on `src_bus`
- SEL_W, 6, width of `sel`
- PAGE_W, 1, width of `page`
- DIV, 200000, clock cycles per digit refresh tick (≥2)

- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- src_bus  in  NUM_SRC*DATA_W  source words; word k = `src_bus[k*DATA_W +: DATA_W]` (k=0 is PC)
- sel  in  SEL_W  source index, asynchronous (switches)
- page  in  PAGE_W  nibble-window index, asynchronous
- blank_lz  in  1  leading-zero blanking enable, asynchronous
- freeze  in  1  hold the displayed value, asynchronous
- annode  out  NUM_DIGITS  digit enables, one-hot, active-high; bit i = digit i, with digit 0 the least significant
- cathod  out  7  segments {a,b,c,d,e,f,g}, active-low

## Operation
**Input synchronisers**
- `sel`, `page`, `blank_lz` and `freeze` each pass through a 2-flop synchroniser. All internal logic uses the synchronised copies only.

**Source selection**
- Window = `src[sel] >> (page*4*NUM_DIGITS)`, truncated to 4*NUM_DIGITS bits.
- Bits above DATA_W read as 0.
- `sel ≥ NUM_SRC` gives a window of 0.

**Prescaler**
- Counter runs 0..DIV-1.
- `tick` asserts for one cycle when count==DIV-1; count then wraps to 0.

**Digit pointer `p`**
- Resets to NUM_DIGITS-1.
- On each tick, the outputs drive digit `p`, then `p` decrements. After 0 it wraps to NUM_DIGITS-1, so the scan runs MSD first.

**Frame register `frame_val`** (4*NUM_DIGITS bits)
- Resets to 0.
- Loaded with the window on the tick that drives digit 0, unless `freeze`=1, in which case it holds.
- The digit-0 nibble on that same tick uses the old `frame_val`, so each frame is self-consistent.

**Per-tick output update (registered)**
- `annode <= 1<<p`.
- `cathod <= blank ? 7'h7F : hex(frame_val[4p+:4])`.

**Blanking**
- Digit p is blank iff `blank_lz`=1, p>0, and every nibble of `frame_val` at positions ≥p is zero.
- Digit 0 is never blanked.

**Hex encoding** (nibble:value, hex)
- 0:01, 1:4F, 2:12, 3:06, 4:4C, 5:24, 6:20, 7:0F
- 8:00, 9:04, A:08, B:60, C:31, D:42, E:30, F:38

## Timing
**Reset** (asynchronous assert, while `reset`=0)
- `annode`=0, `cathod`=7'h7F.
- Prescaler=0, `p`=NUM_DIGITS-1, `frame_val`=0, synchroniser flops cleared.
- Release is taken on the next rising edge.

**Outputs between ticks**
- `annode` and `cathod` change only on tick edges and hold otherwise. There is no blank gap between digits.
- First tick after reset: DIV cycles after release, driving the MSD.
- A full frame lasts NUM_DIGITS*DIV cycles. Every digit is enabled for exactly DIV cycles per frame.

**Input latency**
- An input change is seen by internal logic 2 cycles later.
- It is captured at the next digit-0 tick.
- It first appears on the MSD of the following frame.

**Switch change mid-frame**
- The current frame completes with the old value. There is no tearing.

**Freeze**
- If `freeze` rises mid-frame, the current frame completes and the value captured at the most recent digit-0 tick is kept indefinitely.
- When `freeze` falls, capture resumes at the next digit-0 tick.

**Reset mid-frame**
- Immediate return to the reset state. After release, scanning restarts at the MSD with `frame_val`=0.

**Blanking mode**
- `blank_lz` takes effect on the next tick, independent of frame boundaries.

## Test plan
Bench parameters: DIV=4, NUM_DIGITS=4, DATA_W=32, NUM_SRC=32, PAGE_W=1.

1. **Reset defaults**
   - Stimulus: assert reset mid-scan.
   - Required: `annode`=0 and `cathod`=7F asynchronously; after release the first change comes 4 cycles later, with `annode`=4'b1000 and `cathod`=01.
2. **Scan and capture**
   - Stimulus: src[0]=32'h0000_12AB, sel=0.
   - Required: from the second frame, digits 3..0 show 4F, 12, 08, 60, with `annode` 1000→0100→0010→0001, each held 4 cycles.
3. **Page and out-of-range select**
   - Stimulus: src[5]=32'hDEAD_BEEF, sel=5, page=1.
   - Required: DEAD is displayed (42, 30, 08, 42).
   - Stimulus: then sel=40.
   - Required: next frame shows 0000.
4. **Leading-zero blanking**
   - Stimulus: src[1]=32'h0000_0070, blank_lz=1.
   - Required: digits 3 and 2 are 7F, digit 1 is 0F, digit 0 is 01.
   - Stimulus: src[1]=0.
   - Required: only digit 0 is lit, showing 01.
5. **No tearing and freeze**
   - Stimulus: change sel mid-frame.
   - Required: the remaining digits of that frame keep the old value; the new value appears at the next MSD.
   - Stimulus: freeze=1, then change the source.
   - Required: the display holds the old value for ≥3 frames.
   - Stimulus: freeze=0.
   - Required: the new value appears after the next digit-0 tick.
6. **Synchroniser latency**
   - Stimulus: pulse sel to a new value 1 cycle before a digit-0 tick.
   - Required: the value is not captured on that tick; it is captured one frame later.
